// File: rtl/instruction_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_cache_if
//  Description : Bundles the fetcher-side read port and the memory-side
//                request/response port of the instruction cache.
//                slave  = cache view, master = fetcher/memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_cache_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int INST_WIDTH = 32
);
    // Fetcher side
    logic [ADDR_WIDTH-1:0] inst_fetch_addr;
    logic                  inst_fetch_done;
    logic [INST_WIDTH-1:0] inst_fetch_data;

    // Memory controller side
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [INST_WIDTH-1:0] mem_resp_data;

    modport slave (
        input  inst_fetch_addr,
        output inst_fetch_done,
        output inst_fetch_data,
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport master (
        output inst_fetch_addr,
        input  inst_fetch_done,
        input  inst_fetch_data,
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_cache
//  Description : Direct-mapped, read-only instruction cache. Hits answer one
//                cycle after lookup; misses fill a whole line from memory one
//                word at a time with a single outstanding request.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache #(
    parameter int ADDR_WIDTH   = 17,
    parameter int INST_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          rdy,
    instruction_cache_if.slave bus
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam int INDEX_LSB = OFFSET_WIDTH + 2;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;
    localparam int LINE_W    = ADDR_WIDTH - INDEX_LSB;

    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;
    localparam logic [OFFSET_WIDTH-1:0] ONE_WORD  = 1;

    typedef enum logic [1:0] {
        ST_LOOKUP = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REQ    = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                   state_q,      state_d;
    logic [OFFSET_WIDTH-1:0]  counter_q,    counter_d;
    logic [LINE_W-1:0]        line_addr_q,  line_addr_d;   // {tag, index} of line being filled
    logic                     done_q,       done_d;
    logic [INST_WIDTH-1:0]    fetch_data_q, fetch_data_d;
    logic                     req_valid_q,  req_valid_d;
    logic [ADDR_WIDTH-1:0]    req_addr_q,   req_addr_d;

    logic [LINES-1:0]         valid_q;
    logic [TAG_WIDTH-1:0]     tag_q  [LINES];
    logic [INST_WIDTH-1:0]    line_q [LINES][WORDS];

    // ------------------------------------------------------------------------
    // Address decode of the standing fetch request
    // ------------------------------------------------------------------------
    logic [OFFSET_WIDTH-1:0]  lk_word;
    logic [INDEX_WIDTH-1:0]   lk_index;
    logic [TAG_WIDTH-1:0]     lk_tag;
    logic                     lk_hit;
    logic [INST_WIDTH-1:0]    lk_data;
    logic                     unused_byte_bits;

    assign lk_word          = bus.inst_fetch_addr[INDEX_LSB-1:2];
    assign lk_index         = bus.inst_fetch_addr[TAG_LSB-1:INDEX_LSB];
    assign lk_tag           = bus.inst_fetch_addr[ADDR_WIDTH-1:TAG_LSB];
    assign lk_hit           = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
    assign lk_data          = line_q[lk_index][lk_word];
    assign unused_byte_bits = ^bus.inst_fetch_addr[1:0];

    // ------------------------------------------------------------------------
    // Fill-side decode of the latched line
    // ------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0]   fill_index;
    logic [TAG_WIDTH-1:0]     fill_tag;
    logic [OFFSET_WIDTH-1:0]  counter_inc;
    logic                     fill_we;
    logic                     fill_last;

    assign fill_index  = line_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag    = line_addr_q[LINE_W-1:INDEX_WIDTH];
    assign counter_inc = counter_q + ONE_WORD;

    // Next-state and output logic; everything holds while rdy is low
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        line_addr_d  = line_addr_q;
        done_d       = done_q;
        fetch_data_d = fetch_data_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        fill_we      = 1'b0;
        fill_last    = 1'b0;

        if (rdy) begin
            case (state_q)
                ST_LOOKUP: begin
                    if (lk_hit) begin
                        done_d       = 1'b1;
                        fetch_data_d = lk_data;
                        state_d      = ST_HOLD;
                    end else begin
                        done_d      = 1'b0;
                        line_addr_d = bus.inst_fetch_addr[ADDR_WIDTH-1:INDEX_LSB];
                        counter_d   = '0;
                        req_valid_d = 1'b1;
                        req_addr_d  = {bus.inst_fetch_addr[ADDR_WIDTH-1:INDEX_LSB],
                                       {OFFSET_WIDTH{1'b0}}, 2'b00};
                        state_d     = ST_REQ;
                    end
                end
                // Forces a done=0 cycle between consecutive pulses
                ST_HOLD: begin
                    done_d  = 1'b0;
                    state_d = ST_LOOKUP;
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_d = 1'b0;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        fill_we = 1'b1;
                        if (counter_q == LAST_WORD) begin
                            fill_last = 1'b1;
                            state_d   = ST_LOOKUP;
                        end else begin
                            counter_d   = counter_inc;
                            req_valid_d = 1'b1;
                            req_addr_d  = {line_addr_q, counter_inc, 2'b00};
                            state_d     = ST_REQ;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOOKUP;
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOOKUP;
            counter_q    <= '0;
            line_addr_q  <= '0;
            done_q       <= 1'b0;
            fetch_data_q <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            line_addr_q  <= line_addr_d;
            done_q       <= done_d;
            fetch_data_q <= fetch_data_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
        end
    end

    // Valid bits: cleared on reset, set when the last word of a line lands
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_we && fill_last) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // Data and tag storage, not reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            line_q[fill_index][counter_q] <= bus.mem_resp_data;
            if (fill_last) begin
                tag_q[fill_index] <= fill_tag;
            end
        end
    end

    assign bus.inst_fetch_done = done_q;
    assign bus.inst_fetch_data = fetch_data_q;
    assign bus.mem_req_valid   = req_valid_q;
    assign bus.mem_req_addr    = req_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_cache
//  Description : Self-checking bench for instruction_cache with a memory
//                responder, request scoreboard and fetch-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_cache;

    logic clk;
    logic rst;
    logic rdy;

    instruction_cache_if #(.ADDR_WIDTH(17), .INST_WIDTH(32)) bus ();

    instruction_cache #(
        .ADDR_WIDTH  (17),
        .INST_WIDTH  (32),
        .INDEX_WIDTH (4),
        .OFFSET_WIDTH(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    logic [16:0] exp_req [$];
    logic [31:0] exp_data[$];

    logic        drv_rst;
    logic [16:0] drv_fetch_addr;

    bit          resp_pending, resp_hold, hold_arm, rdy_arm, stall_active;
    bit          prev_done, prev_rdy, done_seen;
    logic [16:0] resp_addr, hold_addr, rdy_addr, stall_addr;
    int          stall_left, rdy_low_left, done_cyc;
    logic [31:0] done_data;

    // Backing-store contents seen by the cache
    function automatic logic [31:0] mem_word(input logic [16:0] a);
        case (a)
            17'h0:   return 32'h11;
            17'h4:   return 32'h22;
            17'h8:   return 32'h33;
            17'hC:   return 32'h44;
            default: return 32'hC0DE_0000 | {15'd0, a};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: observe outputs at negedge, act as memory, drive next inputs
    task automatic step();
        logic [31:0] exp_w;
        bit          rdy_v;
        bit          ready_v;
        bit          rv;
        logic [31:0] rd;
        @(negedge clk);
        cyc++;
        exp_w = exp_data.pop_front();
        if (bus.inst_fetch_done === 1'b1) begin
            if (prev_rdy) check_eq("pulse_gap", {31'd0, prev_done}, 32'd0);
            check_eq("fetch_data", bus.inst_fetch_data, exp_w);
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_data = bus.inst_fetch_data;
        end
        prev_done = (bus.inst_fetch_done === 1'b1);

        rdy_v   = 1'b1;
        ready_v = 1'b1;
        rv      = 1'b0;
        rd      = 32'hDEAD_BEEF;

        if (rdy_arm && resp_pending && resp_addr == rdy_addr) begin
            rdy_arm      = 1'b0;
            rdy_low_left = 3;
        end
        if (rdy_low_left > 0) begin
            rdy_low_left--;
            rdy_v = 1'b0;
            rv    = 1'b1;
            rd    = ~mem_word(resp_addr);
            check_eq("rdy_freeze_req", {31'd0, bus.mem_req_valid}, 32'd0);
        end else if (resp_pending && !resp_hold) begin
            rv           = 1'b1;
            rd           = mem_word(resp_addr);
            resp_pending = 1'b0;
        end

        if (stall_left > 0 && (stall_active || (bus.mem_req_valid === 1'b1 && bus.mem_req_addr == stall_addr))) begin
            stall_active = 1'b1;
            stall_left--;
            ready_v = 1'b0;
            check_eq("bp_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            check_eq("bp_addr", {15'd0, bus.mem_req_addr}, {15'd0, stall_addr});
        end else begin
            stall_active = 1'b0;
        end

        if (bus.mem_req_valid === 1'b1 && ready_v && rdy_v && !drv_rst) begin
            check_eq("req_expected", {31'd0, exp_req.size() > 0}, 32'd1);
            if (exp_req.size() > 0) check_eq("req_addr", {15'd0, bus.mem_req_addr}, {15'd0, exp_req.pop_front()});
            resp_pending = 1'b1;
            resp_addr    = bus.mem_req_addr;
            if (hold_arm && bus.mem_req_addr == hold_addr) begin
                hold_arm  = 1'b0;
                resp_hold = 1'b1;
            end
        end

        rst                 = drv_rst;
        rdy                 = rdy_v;
        bus.mem_req_ready   = ready_v;
        bus.mem_resp_valid  = rv;
        bus.mem_resp_data   = rd;
        bus.inst_fetch_addr = drv_fetch_addr;
        exp_data.push_back(mem_word(drv_fetch_addr));
        prev_rdy = rdy_v;
    endtask

    // Wait (bounded) for the next done pulse and check data/latency
    task automatic wait_done(input string tag, input int t0, input logic [31:0] exp_d, input int exp_lat);
        int n;
        n         = 0;
        done_seen = 1'b0;
        while (!done_seen && n < 80) begin
            step();
            n++;
        end
        check_eq({tag, "_seen"}, {31'd0, done_seen}, 32'd1);
        if (done_seen) begin
            check_eq({tag, "_data"}, done_data, exp_d);
            if (exp_lat >= 0) check_eq({tag, "_lat"}, done_cyc - t0, exp_lat);
        end
    endtask

    task automatic push_line(input logic [16:0] base, input int nwords);
        for (int i = 0; i < nwords; i++) exp_req.push_back(base + 17'(4 * i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_done"},  {31'd0, bus.inst_fetch_done}, 32'd0);
        check_eq({tag, "_data"},  bus.inst_fetch_data, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
        check_eq({tag, "_addr"},  {15'd0, bus.mem_req_addr}, 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        clk = 1'b0; rst = 1'b1; rdy = 1'b1;
        bus.inst_fetch_addr = '0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        n_checks = 0; n_errors = 0; cyc = 0;
        drv_rst = 1'b1; drv_fetch_addr = '0;
        resp_pending = 0; resp_hold = 0; hold_arm = 0; rdy_arm = 0; stall_active = 0;
        prev_done = 0; prev_rdy = 1; done_seen = 0;
        resp_addr = '0; hold_addr = '0; rdy_addr = '0; stall_addr = '0;
        stall_left = 0; rdy_low_left = 0; done_cyc = 0; done_data = '0;
        exp_data.push_back(32'd0);

        // Reset state
        repeat (3) step();
        check_reset_outputs("rst");

        // Cold miss at 0x0: four ordered requests, done 10 cycles later
        push_line(17'h0, 4);
        drv_rst = 1'b0;
        step();
        t0 = cyc;
        wait_done("cold", t0, 32'h11, 10);
        check_eq("cold_reqs_left", exp_req.size(), 0);

        // Hit at 0x8 one cycle after lookup, preceded by a done=0 cycle
        drv_fetch_addr = 17'h8;
        step();
        check_eq("hit_gap", {31'd0, bus.inst_fetch_done}, 32'd0);
        t0 = cyc;
        wait_done("hit", t0, 32'h33, 1);
        check_eq("hit_reqs_left", exp_req.size(), 0);

        // Conflict on index 0 with tag 1
        push_line(17'h100, 4);
        drv_fetch_addr = 17'h100;
        step();
        wait_done("conflict", cyc, mem_word(17'h100), -1);
        check_eq("conflict_reqs_left", exp_req.size(), 0);

        // Refetch 0x0 with five cycles of backpressure on the second word
        push_line(17'h0, 4);
        stall_addr = 17'h4;
        stall_left = 5;
        drv_fetch_addr = 17'h0;
        step();
        wait_done("refetch", cyc, 32'h11, -1);
        check_eq("bp_cycles_left", stall_left, 0);
        check_eq("refetch_reqs_left", exp_req.size(), 0);

        // rdy low for 3 cycles while a corrupted response is offered
        push_line(17'h140, 4);
        rdy_addr = 17'h148;
        rdy_arm  = 1'b1;
        drv_fetch_addr = 17'h144;
        step();
        wait_done("rdy_fill", cyc, mem_word(17'h144), -1);
        check_eq("rdy_window_used", {31'd0, rdy_arm}, 32'd0);
        drv_fetch_addr = 17'h148;
        step();
        wait_done("rdy_word", cyc, mem_word(17'h148), -1);
        check_eq("rdy_reqs_left", exp_req.size(), 0);

        // Reset while waiting for the second word of a fill
        push_line(17'h20, 2);
        hold_addr = 17'h24;
        hold_arm  = 1'b1;
        drv_fetch_addr = 17'h20;
        step();
        n = 0;
        while (!resp_hold && n < 40) begin
            step();
            n++;
        end
        check_eq("hold_reached", {31'd0, resp_hold}, 32'd1);
        step();
        drv_rst = 1'b1;
        step();
        drv_rst   = 1'b0;
        resp_hold = 1'b0;
        drv_fetch_addr = 17'h0;
        push_line(17'h0, 4);
        step();
        check_reset_outputs("rst_mid");
        t0 = cyc;
        wait_done("post_rst", t0, 32'h11, 10);
        check_eq("post_rst_reqs_left", exp_req.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
